// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite signal bundle between a single master and the memory responder.
interface ahb_mem_slave_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic [1:0]  HRESP;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_mem_slave.sv
// AHB-Lite responder over a 2**ADDR_WIDTH x 32b word store; two-cycle ERROR on bad address/size/alignment.
// Zero-wait data phase; with AHB_MEM_SLAVE_WAIT_EN defined, HREADYOUT stalls each legal transfer WAIT_CYCLES cycles.
module ahb_mem_slave #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic           HCLK,
   input  logic           HRESETn,
   ahb_mem_slave_if.slave io_ahb
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t                r_state;
   logic                  r_hreadyout;
   logic [1:0]            r_hresp;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_lane;
   logic [1:0]            r_size;
   logic                  r_write;
   logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];
`ifdef AHB_MEM_SLAVE_WAIT_EN
   logic [3:0]            r_wait_cnt;
`endif

   logic                  w_accept;
   logic                  w_illegal;
   logic [3:0]            w_be;
   logic                  w_unused;

   assign w_accept  = io_ahb.HSEL & io_ahb.HREADY & io_ahb.HTRANS[1];
   assign w_illegal = (|io_ahb.HADDR[31:ADDR_WIDTH+2])
                    | (io_ahb.HSIZE > 3'b010)
                    | ((io_ahb.HSIZE == 3'b001) & io_ahb.HADDR[0])
                    | ((io_ahb.HSIZE == 3'b010) & (|io_ahb.HADDR[1:0]));
   // HBURST is informational only: every beat carries its own address.
   assign w_unused  = ^{io_ahb.HBURST, io_ahb.HTRANS[0]} ^ (WAIT_CYCLES != 0);

   always_comb begin
      w_be = 4'b0000;
      case (r_size)
         2'b00:   w_be = 4'b0001 << r_lane;
         2'b01:   w_be = r_lane[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= S_IDLE;
         r_hreadyout <= 1'b1;
         r_hresp     <= 2'b00;
         r_addr      <= '0;
         r_lane      <= 2'b00;
         r_size      <= 2'b00;
         r_write     <= 1'b0;
`ifdef AHB_MEM_SLAVE_WAIT_EN
         r_wait_cnt  <= 4'd0;
`endif
      end else begin
         case (r_state)
            // ERR2 drives HREADYOUT high, so it takes a new address phase like IDLE.
            S_IDLE, S_DATA, S_ERR2: begin
               r_state     <= S_IDLE;
               r_hreadyout <= 1'b1;
               r_hresp     <= 2'b00;
               if (w_accept) begin
                  r_addr  <= io_ahb.HADDR[ADDR_WIDTH+1:2];
                  r_lane  <= io_ahb.HADDR[1:0];
                  r_size  <= io_ahb.HSIZE[1:0];
                  r_write <= io_ahb.HWRITE;
                  if (w_illegal) begin
                     r_state     <= S_ERR1;
                     r_hreadyout <= 1'b0;
                     r_hresp     <= 2'b01;
                  end
`ifdef AHB_MEM_SLAVE_WAIT_EN
                  else if (WAIT_CYCLES > 0) begin
                     r_state     <= S_WAIT;
                     r_hreadyout <= 1'b0;
                     r_wait_cnt  <= 4'd1;
                  end
`endif
                  else begin
                     r_state <= S_DATA;
                  end
               end
            end
`ifdef AHB_MEM_SLAVE_WAIT_EN
            S_WAIT: begin
               if (r_wait_cnt == 4'(WAIT_CYCLES)) begin
                  r_state     <= S_DATA;
                  r_hreadyout <= 1'b1;
                  r_wait_cnt  <= 4'd0;
               end else begin
                  r_wait_cnt  <= r_wait_cnt + 4'd1;
               end
            end
`endif
            S_ERR1: begin
               r_state     <= S_ERR2;
               r_hreadyout <= 1'b1;
               r_hresp     <= 2'b01;
            end
            default: begin
               r_state     <= S_IDLE;
               r_hreadyout <= 1'b1;
               r_hresp     <= 2'b00;
            end
         endcase
      end
   end

   // Contents are deliberately not reset; a reset forces IDLE, so a pending write never lands.
   always_ff @(posedge HCLK) begin
      if (r_state == S_DATA && r_write) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[r_addr][8*i +: 8] <= io_ahb.HWDATA[8*i +: 8];
         end
      end
   end

   assign io_ahb.HRDATA    = (r_state == S_DATA) ? r_mem[r_addr] : 32'h0;
   assign io_ahb.HREADYOUT = r_hreadyout;
   assign io_ahb.HRESP     = r_hresp;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: directed vector table, pipelined bursts, reset abort, randomized traffic vs a byte-level model.
module tb_ahb_mem_slave;
   localparam int AW = 8;
`ifdef AHB_MEM_SLAVE_WAIT_EN
   localparam int EXP_WAITS = 2;
`else
   localparam int EXP_WAITS = 0;
`endif

   typedef struct {
      logic        wr;
      logic [2:0]  sz;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        err;
      logic        chk;
      logic [31:0] rd;
   } vec_t;

   typedef struct {
      logic        wr;
      logic [2:0]  sz;
      logic [31:0] addr;
      logic [31:0] wd;
   } beat_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   vec_t  vecs [17];
   beat_t pq [$];
   logic [7:0] ref_mem [logic [31:0]];

   ahb_mem_slave_if bus ();
   assign bus.HREADY = bus.HREADYOUT;

   ahb_mem_slave #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut (
      .HCLK    (clk),
      .HRESETn (rstn),
      .io_ahb  (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference rules: in range, legal size, naturally aligned.
   function automatic bit legal(input logic [2:0] sz, input logic [31:0] a);
      if (sz > 3'd2) return 1'b0;
      if (a >= (32'd4 << AW)) return 1'b0;
      return (a & ((32'd1 << sz) - 32'd1)) == 32'd0;
   endfunction

   task automatic model_write(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] b;
      if (legal(sz, a)) begin
         for (int k = 0; k < (1 << sz); k++) begin
            b = a + 32'(k);
            ref_mem[b] = wd[{b[1:0], 3'b000} +: 8];
         end
      end
   endtask

   task automatic model_read(input logic [31:0] a, output logic [31:0] w, output bit known);
      logic [31:0] b;
      w = '0;
      known = 1'b1;
      for (int k = 0; k < 4; k++) begin
         b = {a[31:2], 2'b00} + 32'(k);
         if (ref_mem.exists(b)) w[8*k +: 8] = ref_mem[b];
         else known = 1'b0;
      end
   endtask

   task automatic bus_idle();
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HWRITE = 1'b0;
      bus.HSIZE  = 3'b000;
      bus.HADDR  = 32'h0;
      bus.HBURST = 3'b000;
      bus.HWDATA = 32'h0;
   endtask

   task automatic idle_check(input string name, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         check(name, {bus.HREADYOUT, bus.HRESP, bus.HRDATA}, {1'b1, 2'b00, 32'h0});
         @(posedge clk); #1;
      end
   endtask

   // Single non-pipelined transfer with master driving IDLE after the address phase.
   task automatic xfer(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input logic err, input logic chk, input logic [31:0] rd, input string name);
      int waits = 0;
      bit done  = 1'b0;
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HWRITE = wr;
      bus.HSIZE  = sz;
      bus.HADDR  = a;
      bus.HBURST = 3'b000;
      @(posedge clk); #1;
      bus_idle();
      bus.HWDATA = wd;
      if (err) begin
         @(negedge clk);
         check({name, " err1"}, {bus.HREADYOUT, bus.HRESP}, 3'b001);
         @(posedge clk); #1;
         @(negedge clk);
         check({name, " err2"}, {bus.HREADYOUT, bus.HRESP}, 3'b101);
      end else begin
         while (!done && waits <= 20) begin
            @(negedge clk);
            if (bus.HREADYOUT) done = 1'b1;
            else begin
               waits++;
               @(posedge clk); #1;
            end
         end
         check({name, " waits"}, waits, EXP_WAITS);
         check({name, " resp"}, bus.HRESP, 2'b00);
         if (chk) check({name, " rdata"}, bus.HRDATA, rd);
      end
      @(posedge clk); #1;
   endtask

   task automatic add_beat(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
      beat_t b;
      b.wr = wr; b.sz = sz; b.addr = a; b.wd = wd;
      pq.push_back(b);
   endtask

   // Pipelined run of pq: next address phase overlaps the current data phase, held while HREADYOUT is low.
   task automatic pipe_run(input string name);
      int    i = 0;
      int    n;
      int    budget = 0;
      int    waits = 0;
      bit    pend = 1'b0;
      bit    known;
      beat_t cur, pb;
      logic [31:0] exp_w;
      n = pq.size();
      while ((i < n || pend) && budget < 200) begin
         budget++;
         if (i < n) begin
            cur        = pq[i];
            bus.HSEL   = 1'b1;
            bus.HTRANS = (i == 0 || cur.addr != pq[i-1].addr + 32'd4) ? 2'b10 : 2'b11;
            bus.HBURST = 3'b001;
            bus.HWRITE = cur.wr;
            bus.HSIZE  = cur.sz;
            bus.HADDR  = cur.addr;
         end else begin
            bus.HSEL   = 1'b0;
            bus.HTRANS = 2'b00;
         end
         if (pend) bus.HWDATA = pb.wd;
         @(negedge clk);
         if (!bus.HREADYOUT) waits++;
         else begin
            if (pend) begin
               check({name, " waits"}, waits, EXP_WAITS);
               check({name, " resp"}, bus.HRESP, 2'b00);
               if (pb.wr) model_write(pb.sz, pb.addr, pb.wd);
               else begin
                  model_read(pb.addr, exp_w, known);
                  if (known) check($sformatf("%s rdata@%0h", name, pb.addr), bus.HRDATA, exp_w);
               end
               pend = 1'b0;
            end
            if (i < n) begin
               pb    = cur;
               pend  = 1'b1;
               waits = 0;
               i++;
            end
         end
         @(posedge clk); #1;
      end
      check({name, " done"}, (i == n && !pend), 1'b1);
      bus_idle();
      pq.delete();
   endtask

   initial begin
      logic        wr;
      logic [2:0]  sz;
      logic [31:0] a, wd, exp_w;
      bit          ok, known;

      bus_idle();
      vecs[0]  = '{1'b1, 3'd2, 32'h010, 32'h00000000, 1'b0, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 3'd0, 32'h011, 32'h1122AA44, 1'b0, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 3'd2, 32'h010, 32'h0,        1'b0, 1'b1, 32'h0000AA00};
      vecs[3]  = '{1'b1, 3'd1, 32'h012, 32'h12345678, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{1'b0, 3'd2, 32'h010, 32'h0,        1'b0, 1'b1, 32'h1234AA00};
      vecs[5]  = '{1'b1, 3'd2, 32'h400, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 3'd2, 32'h002, 32'h0,        1'b1, 1'b0, 32'h0};
      vecs[7]  = '{1'b1, 3'd1, 32'h011, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
      vecs[8]  = '{1'b1, 3'd3, 32'h010, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
      vecs[9]  = '{1'b1, 3'd2, 32'h80000010, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
      vecs[10] = '{1'b1, 3'd0, 32'h010, 32'hFFFFFF66, 1'b0, 1'b0, 32'h0};
      vecs[11] = '{1'b0, 3'd2, 32'h010, 32'h0,        1'b0, 1'b1, 32'h1234AA66};
      vecs[12] = '{1'b1, 3'd2, 32'h3FC, 32'h00000000, 1'b0, 1'b0, 32'h0};
      vecs[13] = '{1'b1, 3'd0, 32'h3FF, 32'h5A000000, 1'b0, 1'b0, 32'h0};
      vecs[14] = '{1'b0, 3'd2, 32'h3FC, 32'h0,        1'b0, 1'b1, 32'h5A000000};
      vecs[15] = '{1'b0, 3'd0, 32'h013, 32'h0,        1'b0, 1'b1, 32'h1234AA66};
      vecs[16] = '{1'b0, 3'd1, 32'h3FE, 32'h0,        1'b0, 1'b1, 32'h5A000000};

      repeat (2) @(posedge clk);
      #1;
      check("in_reset", {bus.HREADYOUT, bus.HRESP, bus.HRDATA}, {1'b1, 2'b00, 32'h0});
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      idle_check("idle", 4);

      add_beat(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      add_beat(1'b0, 3'd2, 32'h10, 32'h0);
      pipe_run("b2b");

      for (int v = 0; v < 17; v++)
         xfer(vecs[v].wr, vecs[v].sz, vecs[v].addr, vecs[v].wd, vecs[v].err, vecs[v].chk, vecs[v].rd,
              $sformatf("vec%0d", v));

      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b10;
      bus.HWRITE = 1'b1;
      bus.HSIZE  = 3'b010;
      bus.HADDR  = 32'h10;
      bus.HWDATA = 32'hFFFFFFFF;
      idle_check("unselected", 3);
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b01;
      idle_check("busy", 3);
      bus_idle();
      xfer(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1, 32'h1234AA66, "no_accept_readback");

      for (int i = 0; i < 16; i++) begin
         a  = 32'h80 + 32'(4 * i);
         wd = $urandom;
         xfer(1'b1, 3'd2, a, wd, 1'b0, 1'b0, 32'h0, "prefill");
         model_write(3'd2, a, wd);
      end
      for (int n = 0; n < 80; n++) begin
         wr = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         a  = 32'h80 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) a = a | (($urandom_range(0, 1) == 1) ? 32'h400 : 32'h80000000);
         wd = $urandom;
         ok = legal(sz, a);
         exp_w = 32'h0;
         known = 1'b0;
         if (!wr && ok) model_read(a, exp_w, known);
         xfer(wr, sz, a, wd, !ok, (!wr && ok && known), exp_w, $sformatf("rnd%0d", n));
         if (wr) model_write(sz, a, wd);
      end

      add_beat(1'b1, 3'd2, 32'h40, 32'h40404040);
      pipe_run("pre40");
      for (int i = 0; i < 4; i++) add_beat(1'b1, 3'd2, 32'h30 + 32'(4 * i), 32'(i + 1));
      pipe_run("burst_wr");

      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HWRITE = 1'b1;
      bus.HSIZE  = 3'b010;
      bus.HADDR  = 32'h40;
      @(posedge clk); #1;
      bus_idle();
      bus.HWDATA = 32'hBAD0BAD0;
      @(negedge clk);
      check("rst_pre_ready", bus.HREADYOUT, (EXP_WAITS == 0));
      rstn = 1'b0;
      #1;
      check("rst_async", {bus.HREADYOUT, bus.HRESP, bus.HRDATA}, {1'b1, 2'b00, 32'h0});
      @(posedge clk); #1;
      check("rst_hold", {bus.HREADYOUT, bus.HRESP, bus.HRDATA}, {1'b1, 2'b00, 32'h0});
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      bus_idle();
      idle_check("post_rst", 2);

      for (int i = 0; i < 4; i++) add_beat(1'b0, 3'd2, 32'h30 + 32'(4 * i), 32'h0);
      add_beat(1'b0, 3'd2, 32'h40, 32'h0);
      pipe_run("readback");
      xfer(1'b0, 3'd2, 32'h38, 32'h0, 1'b0, 1'b1, 32'h3, "burst_beat3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ahb_mem_slave.md
# ahb_mem_slave

AHB-Lite responder backed by an internal word-addressed register-file memory, the target a single AHB master (read or write engine) transacts against. Decodes address/data phases, commits byte/halfword/word writes, returns read data, inserts optional wait states and produces two-cycle ERROR responses for out-of-range or misaligned accesses. Sits on the fabric as the slave end of the master port; also used standalone as the bench target for master verification.

## Interface
- ADDR_WIDTH, 8, word-address bits; memory depth 2**ADDR_WIDTH words of 32 bits
- WAIT_CYCLES, 2, wait states per transfer when `AHB_MEM_SLAVE_WAIT_EN` is defined (1..15)

- HCLK  in  1  clock; all state changes on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  1 write, 0 read
- HSIZE  in  3  000 byte, 001 halfword, 010 word; others illegal
- HBURST  in  3  accepted, not interpreted (every beat carries its own HADDR)
- HWDATA  in  32  write data, data phase
- HREADY  in  1  bus ready; address phase accepted only when high
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  2  00 OKAY, 01 ERROR

## Operation
- Transfer accepted on edge where HSEL & HREADY & HTRANS[1]; captures HADDR, HWRITE, HSIZE. IDLE/BUSY or HSEL=0 never accepted → zero-wait OKAY.
- Error conditions at accept: HADDR[31:ADDR_WIDTH+2] != 0; HSIZE > 010; halfword with HADDR[0]=1; word with HADDR[1:0] != 00.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=OKAY. Accept legal → WAIT (macro on, WAIT_CYCLES>0) else DATA; accept illegal → ERR1.
  - WAIT: HREADYOUT=0, HRESP=OKAY; 4-bit counter counts WAIT_CYCLES cycles → DATA.
  - DATA: HREADYOUT=1, HRESP=OKAY; writes commit at this edge; new accept on same edge → WAIT/DATA/ERR1, else IDLE.
  - ERR1: HREADYOUT=0, HRESP=ERROR → ERR2. ERR2: HREADYOUT=1, HRESP=ERROR; acts as IDLE for accepts (master normally drives IDLE).
- Writes: HWDATA lanes per little-endian HSIZE/HADDR[1:0]; byte lane n = HWDATA[8n+7:8n]; unselected bytes unchanged. Errored transfers never write.
- Reads: HRDATA = full memory word at captured word address during DATA; 0 in all other states. Read immediately following a write to same word returns the new value.
- Memory contents not reset; undefined until written.

## Timing
- Reset values: state IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, wait counter 0.
- Zero-wait: accept edge N, data phase cycle N+1, HREADYOUT=1, HRDATA valid, write commits at end of N+1.
- With waits: HREADYOUT=0 for cycles N+1..N+WAIT_CYCLES, high at N+WAIT_CYCLES+1.
- While HREADYOUT=0 no address phase is accepted (HREADY low on bus).
- Error: HREADYOUT 0 then 1 with HRESP=01 both cycles.
- Reset asserted mid-transfer: immediate return to IDLE outputs; pending write discarded.

## Configuration
- `AHB_MEM_SLAVE_WAIT_EN` defined: every legal transfer inserts WAIT_CYCLES wait states (WAIT state reachable).
- Undefined: WAIT state and counter compiled out; all legal transfers zero-wait; WAIT_CYCLES ignored. Error timing identical both ways.

## Test plan
- Reset, then idle bus → HREADYOUT=1, HRESP=00, HRDATA=0 every cycle.
- Word write 0xDEADBEEF to 0x10, then word read 0x10 back-to-back (macro off) → HRDATA=0xDEADBEEF in cycle after read accept, no wait.
- Byte write 0xAA to 0x11 over word 0x00000000 at 0x10, read 0x10 → 0x0000AA00; halfword write 0x1234 to 0x12 → read 0x1234AA00.
- Macro on, WAIT_CYCLES=2, read 0x20 → HREADYOUT low exactly 2 cycles, then high with data.
- Write to 0x400 (ADDR_WIDTH=8) and word read at 0x02 → each: HREADYOUT=0/HRESP=01, then HREADYOUT=1/HRESP=01; memory unchanged.
- 4-beat INCR write burst 0x30..0x3C with data 1..4, then HRESETn pulse during a WAIT cycle of a following write to 0x40 → readback 1..4 at 0x30..0x3C, 0x40 unchanged, outputs at reset values.
